pool_sequencer: RTL and testbench
=================================

POOL_SEQUENCER -- requirements
Module: pool_sequencer

Interface
REQ-001 SHALL have parameter DESIGN_SIZE, default `DESIGN_SIZE, which is the rows per tile and the elements per row.
REQ-002 SHALL have parameter DWIDTH, default `DWIDTH, which is the element width.
REQ-003 SHALL have parameter MAX_BITS_POOL, default `MAX_BITS_POOL, which is the width of the window-size field.
REQ-004 SHALL have parameter AWIDTH, default 10, which is the buffer address width.
REQ-005 SHALL have ports:
 clk  in  1  clock, rising edge
 resetn  in  1  asynchronous active-low reset
 start  in  1  single-cycle pulse that launches a job
 abort  in  1  synchronous cancel of the current job
 cfg_window  in  MAX_BITS_POOL  pool window size, legal values 1, 2 and 4
 cfg_num_tiles  in  16  tiles in the job; 0 means a null job
 cfg_rd_base  in  AWIDTH  first source row address
 cfg_wr_base  in  AWIDTH  first destination row address
 rd_en  out  1  source read strobe
 rd_addr  out  AWIDTH  source row address
 rd_data  in  DESIGN_SIZE*DWIDTH  source row, valid 1 cycle after rd_en
 pool_enable  out  1  drives pool enable_pool
 pool_window  out  MAX_BITS_POOL  drives pool_window_size
 pool_in_valid  out  1  drives in_data_available
 pool_in_data  out  DESIGN_SIZE*DWIDTH  drives inp_data
 pool_out_valid  in  1  pool out_data_available
 pool_out_data  in  DESIGN_SIZE*DWIDTH  pool out_data
 pool_done  in  1  pool done_pool
 wr_en  out  1  destination write strobe
 wr_addr  out  AWIDTH  destination row address
 wr_data  out  DESIGN_SIZE*DWIDTH  destination row
 busy  out  1  high while a job is active
 done  out  1  single-cycle pulse at job end
 cfg_err  out  1  sticky flag: an illegal window was given; cleared by the next start

Function
REQ-006 The state machine SHALL have the states IDLE, FEED, WAIT_DONE, GAP and FINISH.
REQ-007 In IDLE, start SHALL latch all cfg_* inputs, zero the row and tile counters, set busy and go to FEED. If cfg_num_tiles==0, start SHALL go directly to FINISH.
REQ-008 start while busy SHALL be ignored.
REQ-009 An illegal cfg_window (anything other than 1, 2 or 4) SHALL be replaced by 1 and SHALL set cfg_err.
REQ-010 In FEED, rd_en SHALL be asserted for exactly DESIGN_SIZE consecutive cycles, with rd_addr = rd_base + tile*DESIGN_SIZE + row.
REQ-011 pool_in_valid SHALL be rd_en delayed by 1 cycle, and pool_in_data SHALL equal rd_data in that cycle, giving a combinational pass-through and a latency of 1.
REQ-012 After the last read, FEED SHALL go to WAIT_DONE. WAIT_DONE SHALL hold until pool_done==1 and the last pool_in_valid has been issued.
REQ-013 From WAIT_DONE, the machine SHALL go to GAP for exactly 1 cycle, during which pool_in_valid==0 so that the pool clears its done and count. It SHALL then increment tile and return to FEED, or go to FINISH if tile==num_tiles-1.
REQ-014 pool_enable SHALL be 1 in FEED, WAIT_DONE and GAP, and 0 otherwise, which holds the pool in its cleared state.
REQ-015 pool_window SHALL carry the latched legal window for the whole job.
REQ-016 Every cycle with pool_out_valid==1 and pool_enable==1 SHALL produce wr_en=1 and wr_data=pool_out_data in the same cycle. wr_addr SHALL start at wr_base and increment by 1 after each write, wrapping modulo 2^AWIDTH.
REQ-017 Source address arithmetic SHALL be AWIDTH bits wide and SHALL wrap modulo 2^AWIDTH.
REQ-018 In FINISH, done SHALL pulse for 1 cycle and busy SHALL fall in the same cycle; the next state SHALL be IDLE.
REQ-019 abort SHALL be acted on in any state other than IDLE. It SHALL drop rd_en, pool_in_valid, wr_en and pool_enable on the next edge, clear busy, not pulse done, and go to IDLE.
REQ-020 If abort and start are asserted together in IDLE, start SHALL win.
REQ-021 If pool_done never arrives, the block SHALL wait in WAIT_DONE indefinitely; only abort exits that state.

Reset
REQ-022 resetn low SHALL asynchronously force IDLE and zero all counters, all latched configuration and every output register.
REQ-023 During reset, busy, done, rd_en, wr_en, pool_enable, pool_in_valid and cfg_err SHALL all be 0.
REQ-024 Reset asserted mid-job SHALL discard the job, and no done pulse SHALL follow.

Structure
REQ-025 The state encoding and the legal-window constants (1, 2, 4) SHALL live in a shared pool_pkg, alongside the existing DESIGN_SIZE and DWIDTH defines.
REQ-026 The address generation (base plus tile and row counters) SHALL be a single sub-module named pool_addr_gen; all remaining logic SHALL stay flat.

Verification
REQ-027 With DESIGN_SIZE=4, window=2, tiles=1, rd_base=0 and wr_base=8, the bench SHALL see 4 reads at addresses 0-3, 4 writes at addresses 8-11, done 1 cycle after WAIT_DONE exits, and busy=0 afterwards.
REQ-028 With tiles=3, the bench SHALL see 12 reads at addresses 0-11, pool_in_valid low for exactly one GAP cycle between tiles, 12 writes and exactly one done pulse.
REQ-029 With window=3, the bench SHALL see cfg_err=1, pool_window=1 and wr_data equal to rd_data.
REQ-030 With tiles=0, the bench SHALL see done 1 cycle after start, with no rd_en and no wr_en.
REQ-031 With abort at read 2 of tile 0, the bench SHALL see rd_en and pool_enable at 0 on the next edge, no done pulse, and a subsequent start that runs normally.
REQ-032 With resetn pulsed low in WAIT_DONE, all outputs SHALL be 0 immediately, with no done pulse; with wr_base=1022 and AWIDTH=10, writes SHALL go to 1022, 1023, 0 and 1.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared state encoding, window constants and element-size defaults
// for the pooling sequencer.
`ifndef DESIGN_SIZE
`define DESIGN_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

package pool_pkg;

    localparam int WIN_1 = 1;
    localparam int WIN_2 = 2;
    localparam int WIN_4 = 4;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT_DONE,
        GAP,
        FINISH
    } pool_state_t;

    function automatic logic win_legal(input int w);
        return (w == WIN_1) || (w == WIN_2) || (w == WIN_4);
    endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Source/destination row address generation: latched bases plus
// row and tile counters for reads, a running pointer for writes.
module pool_addr_gen #(
    parameter int DESIGN_SIZE = 4,
    parameter int AWIDTH      = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_load,
    input  logic [AWIDTH-1:0] i_rd_base,
    input  logic [AWIDTH-1:0] i_wr_base,
    input  logic              i_row_step,
    input  logic              i_tile_step,
    input  logic              i_wr_step,
    output logic [AWIDTH-1:0] o_rd_addr,
    output logic [AWIDTH-1:0] o_wr_addr,
    output logic              o_last_row,
    output logic [15:0]       o_tile
);

    localparam int RW = (DESIGN_SIZE > 1) ? $clog2(DESIGN_SIZE) : 1;

    logic [AWIDTH-1:0] r_rd_base;
    logic [AWIDTH-1:0] r_wr_addr;
    logic [RW-1:0]     r_row;
    logic [15:0]       r_tile;
    logic              w_last_row;

    assign w_last_row = (r_row == RW'(DESIGN_SIZE - 1));

    // Row/tile counters; the row wraps to 0 on the last read of a tile.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_base <= '0;
            r_row     <= '0;
            r_tile    <= '0;
        end else if (i_load) begin
            r_rd_base <= i_rd_base;
            r_row     <= '0;
            r_tile    <= '0;
        end else begin
            if (i_row_step)
                r_row <= w_last_row ? '0 : r_row + RW'(1);
            if (i_tile_step)
                r_tile <= r_tile + 16'd1;
        end
    end

    // Destination pointer advances once per written row, wrapping freely.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_wr_addr <= '0;
        else if (i_load)
            r_wr_addr <= i_wr_base;
        else if (i_wr_step)
            r_wr_addr <= r_wr_addr + AWIDTH'(1);
    end

    assign o_rd_addr  = r_rd_base
                      + AWIDTH'(r_tile) * AWIDTH'(DESIGN_SIZE)
                      + AWIDTH'(r_row);
    assign o_wr_addr  = r_wr_addr;
    assign o_last_row = w_last_row;
    assign o_tile     = r_tile;

endmodule

// File: rtl/pool_sequencer.sv
// Pooling sequencer: streams source rows through the pool unit one tile
// at a time and writes each pooled row to the destination buffer.
`ifndef DESIGN_SIZE
`define DESIGN_SIZE 4
`endif
`ifndef DWIDTH
`define DWIDTH 8
`endif
`ifndef MAX_BITS_POOL
`define MAX_BITS_POOL 3
`endif

module pool_sequencer
    import pool_pkg::*;
#(
    parameter int DESIGN_SIZE   = `DESIGN_SIZE,
    parameter int DWIDTH        = `DWIDTH,
    parameter int MAX_BITS_POOL = `MAX_BITS_POOL,
    parameter int AWIDTH        = 10
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          abort,
    input  logic [MAX_BITS_POOL-1:0]      cfg_window,
    input  logic [15:0]                   cfg_num_tiles,
    input  logic [AWIDTH-1:0]             cfg_rd_base,
    input  logic [AWIDTH-1:0]             cfg_wr_base,
    output logic                          rd_en,
    output logic [AWIDTH-1:0]             rd_addr,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] rd_data,
    output logic                          pool_enable,
    output logic [MAX_BITS_POOL-1:0]      pool_window,
    output logic                          pool_in_valid,
    output logic [DESIGN_SIZE*DWIDTH-1:0] pool_in_data,
    input  logic                          pool_out_valid,
    input  logic [DESIGN_SIZE*DWIDTH-1:0] pool_out_data,
    input  logic                          pool_done,
    output logic                          wr_en,
    output logic [AWIDTH-1:0]             wr_addr,
    output logic [DESIGN_SIZE*DWIDTH-1:0] wr_data,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    pool_state_t              r_state;
    pool_state_t              w_next;
    logic [15:0]              r_num_tiles;
    logic [MAX_BITS_POOL-1:0] r_window;
    logic                     r_cfg_err;
    logic                     r_in_valid;
    logic                     w_load;
    logic                     w_row_step;
    logic                     w_tile_step;
    logic                     w_last_row;
    logic                     w_win_ok;
    logic                     w_active;
    logic [15:0]              w_tile;

    assign w_win_ok = win_legal(int'(cfg_window));
    assign w_active = (r_state == FEED) || (r_state == WAIT_DONE)
                   || (r_state == GAP);

    pool_addr_gen #(
        .DESIGN_SIZE (DESIGN_SIZE),
        .AWIDTH      (AWIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .resetn      (resetn),
        .i_load      (w_load),
        .i_rd_base   (cfg_rd_base),
        .i_wr_base   (cfg_wr_base),
        .i_row_step  (w_row_step),
        .i_tile_step (w_tile_step),
        .i_wr_step   (wr_en),
        .o_rd_addr   (rd_addr),
        .o_wr_addr   (wr_addr),
        .o_last_row  (w_last_row),
        .o_tile      (w_tile)
    );

    // Next-state and counter-step decode; abort overrides every busy state.
    always_comb begin
        w_next      = r_state;
        w_load      = 1'b0;
        w_row_step  = 1'b0;
        w_tile_step = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = (cfg_num_tiles == 16'd0) ? FINISH : FEED;
                end
            end
            FEED: begin
                w_row_step = 1'b1;
                if (w_last_row)
                    w_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (pool_done && !r_in_valid)
                    w_next = GAP;
            end
            GAP: begin
                if (w_tile == r_num_tiles - 16'd1) begin
                    w_next = FINISH;
                end else begin
                    w_tile_step = 1'b1;
                    w_next      = FEED;
                end
            end
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort && (r_state != IDLE)) begin
            w_next      = IDLE;
            w_row_step  = 1'b0;
            w_tile_step = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Job configuration latched at start; illegal windows fall back to 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_num_tiles <= '0;
            r_window    <= '0;
            r_cfg_err   <= 1'b0;
        end else if (w_load) begin
            r_num_tiles <= cfg_num_tiles;
            r_window    <= w_win_ok ? cfg_window : MAX_BITS_POOL'(1);
            r_cfg_err   <= !w_win_ok;
        end
    end

    // Pool input strobe trails the read strobe by the buffer latency.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_in_valid <= 1'b0;
        else
            r_in_valid <= rd_en && !abort;
    end

    assign rd_en         = (r_state == FEED);
    assign pool_enable   = w_active;
    assign busy          = w_active;
    assign done          = (r_state == FINISH);
    assign pool_window   = r_window;
    assign pool_in_valid = r_in_valid;
    assign pool_in_data  = rd_data;
    assign wr_en         = pool_out_valid && w_active;
    assign wr_data       = pool_out_data;
    assign cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_pool_sequencer.sv
// Directed testbench for pool_sequencer with a row-echo pool model
// and a pattern-filled source buffer.
module tb_pool_sequencer;

    localparam int DS = 4;
    localparam int DW = 8;
    localparam int MB = 3;
    localparam int AW = 10;
    localparam int RW = DS * DW;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [MB-1:0] cfg_window = '0;
    logic [15:0]   cfg_num_tiles = '0;
    logic [AW-1:0] cfg_rd_base = '0;
    logic [AW-1:0] cfg_wr_base = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data = '0;
    logic          pool_enable;
    logic [MB-1:0] pool_window;
    logic          pool_in_valid;
    logic [RW-1:0] pool_in_data;
    logic          pool_out_valid = 1'b0;
    logic [RW-1:0] pool_out_data = '0;
    logic          pool_done = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [RW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pool_sequencer #(
        .DESIGN_SIZE   (DS),
        .DWIDTH        (DW),
        .MAX_BITS_POOL (MB),
        .AWIDTH        (AW)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .abort          (abort),
        .cfg_window     (cfg_window),
        .cfg_num_tiles  (cfg_num_tiles),
        .cfg_rd_base    (cfg_rd_base),
        .cfg_wr_base    (cfg_wr_base),
        .rd_en          (rd_en),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .pool_enable    (pool_enable),
        .pool_window    (pool_window),
        .pool_in_valid  (pool_in_valid),
        .pool_in_data   (pool_in_data),
        .pool_out_valid (pool_out_valid),
        .pool_out_data  (pool_out_data),
        .pool_done      (pool_done),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .busy           (busy),
        .done           (done),
        .cfg_err        (cfg_err)
    );

    function automatic logic [RW-1:0] pat(input logic [AW-1:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {b ^ 8'hA5, b + 8'd3, ~b, b};
    endfunction

    // Source buffer: one-cycle read latency.
    always @(posedge clk)
        if (rd_en)
            rd_data <= pat(rd_addr);

    // Pool model: echoes each row one cycle later, raises done after
    // DS rows, clears done/count when it sees a cycle with no input.
    int   pcnt = 0;
    logic no_done = 1'b0;
    always @(posedge clk) begin
        if (!pool_enable) begin
            pool_out_valid <= 1'b0;
            pool_done      <= 1'b0;
            pcnt           <= 0;
        end else begin
            pool_out_valid <= pool_in_valid;
            pool_out_data  <= pool_in_data;
            if (pool_done && !pool_in_valid) begin
                pool_done <= 1'b0;
                pcnt      <= 0;
            end else begin
                if (pool_in_valid)
                    pcnt <= pcnt + 1;
                if (pcnt == DS && !no_done)
                    pool_done <= 1'b1;
            end
        end
    end

    // Activity log.
    int            cyc = 0;
    logic [AW-1:0] rq[$];
    logic [AW-1:0] wq[$];
    logic [RW-1:0] dq[$];
    int            ndone = 0;
    int            done_cyc = 0;
    int            ngap = 0;
    logic          prev_pd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_en) rq.push_back(rd_addr);
        if (wr_en) begin
            wq.push_back(wr_addr);
            dq.push_back(wr_data);
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
        if (prev_pd && pool_enable && !pool_in_valid) ngap++;
        prev_pd = pool_done && pool_enable;
    end

    int            t_start;
    logic          s_busy;
    logic [MB-1:0] s_win;
    logic          s_err;

    task automatic clear_log();
        rq.delete();
        wq.delete();
        dq.delete();
        ndone = 0;
        ngap  = 0;
    endtask

    task automatic wait_done(input string nm);
        bit got;
        got = done;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout got done=0 want done=1", nm);
        end
        @(negedge clk);
    endtask

    task automatic run_job(input logic [MB-1:0] w, input logic [15:0] t,
                           input logic [AW-1:0] rb, input logic [AW-1:0] wb);
        @(negedge clk);
        clear_log();
        cfg_window    = w;
        cfg_num_tiles = t;
        cfg_rd_base   = rb;
        cfg_wr_base   = wb;
        start         = 1'b1;
        t_start       = cyc;
        @(negedge clk);
        start  = 1'b0;
        s_busy = busy;
        s_win  = pool_window;
        s_err  = cfg_err;
        wait_done("run_job");
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, wr_en, pool_enable, pool_in_valid, cfg_err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outs got %b want 0000000",
                     {busy, done, rd_en, wr_en, pool_enable, pool_in_valid, cfg_err});
        end
        checks++;
        if (pool_window !== 3'd0) begin
            errors++;
            $display("FAIL reset_win got %0d want 0", pool_window);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b want 0", busy);
        end
    endtask

    task automatic test_single_tile();
        run_job(3'd2, 16'd1, 10'd0, 10'd8);
        checks++;
        if (rq.size() != 4) begin
            errors++;
            $display("FAIL single_nrd got %0d want 4", rq.size());
        end
        for (int i = 0; i < rq.size() && i < 4; i++) begin
            checks++;
            if (rq[i] !== AW'(i)) begin
                errors++;
                $display("FAIL single_rd%0d got %0d want %0d", i, rq[i], i);
            end
        end
        checks++;
        if (wq.size() != 4) begin
            errors++;
            $display("FAIL single_nwr got %0d want 4", wq.size());
        end
        for (int i = 0; i < wq.size() && i < 4; i++) begin
            checks++;
            if (wq[i] !== AW'(8 + i) || dq[i] !== pat(AW'(i))) begin
                errors++;
                $display("FAIL single_wr%0d got %0d/%h want %0d/%h",
                         i, wq[i], dq[i], 8 + i, pat(AW'(i)));
            end
        end
        checks++;
        if (ndone != 1 || done_cyc - t_start != 9) begin
            errors++;
            $display("FAIL single_done got n=%0d dt=%0d want n=1 dt=9",
                     ndone, done_cyc - t_start);
        end
        checks++;
        if (s_busy !== 1'b1 || s_win !== 3'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_status got b=%b w=%0d after=%b want 1 2 0",
                     s_busy, s_win, busy);
        end
    endtask

    task automatic test_multi_tile();
        run_job(3'd2, 16'd3, 10'd0, 10'h20);
        checks++;
        if (rq.size() != 12 || wq.size() != 12) begin
            errors++;
            $display("FAIL multi_counts got rd=%0d wr=%0d want 12 12",
                     rq.size(), wq.size());
        end
        for (int i = 0; i < rq.size() && i < 12; i++) begin
            checks++;
            if (rq[i] !== AW'(i)) begin
                errors++;
                $display("FAIL multi_rd%0d got %0d want %0d", i, rq[i], i);
            end
        end
        for (int i = 0; i < wq.size() && i < 12; i++) begin
            checks++;
            if (wq[i] !== AW'(32 + i)) begin
                errors++;
                $display("FAIL multi_wr%0d got %0d want %0d", i, wq[i], 32 + i);
            end
        end
        checks++;
        if (ngap != 3) begin
            errors++;
            $display("FAIL multi_gaps got %0d want 3", ngap);
        end
        checks++;
        if (ndone != 1 || done_cyc - t_start != 25) begin
            errors++;
            $display("FAIL multi_done got n=%0d dt=%0d want n=1 dt=25",
                     ndone, done_cyc - t_start);
        end
    endtask

    task automatic test_bad_window();
        run_job(3'd3, 16'd1, 10'h40, 10'h80);
        checks++;
        if (s_err !== 1'b1 || s_win !== 3'd1 || cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL badwin got err=%b win=%0d sticky=%b want 1 1 1",
                     s_err, s_win, cfg_err);
        end
        checks++;
        if (dq.size() != 4) begin
            errors++;
            $display("FAIL badwin_nwr got %0d want 4", dq.size());
        end
        for (int i = 0; i < dq.size() && i < 4; i++) begin
            checks++;
            if (dq[i] !== pat(AW'(64 + i))) begin
                errors++;
                $display("FAIL badwin_data%0d got %h want %h",
                         i, dq[i], pat(AW'(64 + i)));
            end
        end
    endtask

    task automatic test_null_job();
        run_job(3'd4, 16'd0, 10'd0, 10'd0);
        checks++;
        if (ndone != 1 || done_cyc - t_start != 1) begin
            errors++;
            $display("FAIL null_done got n=%0d dt=%0d want n=1 dt=1",
                     ndone, done_cyc - t_start);
        end
        checks++;
        if (rq.size() != 0 || wq.size() != 0) begin
            errors++;
            $display("FAIL null_traffic got rd=%0d wr=%0d want 0 0",
                     rq.size(), wq.size());
        end
        checks++;
        if (cfg_err !== 1'b0 || s_win !== 3'd4 || s_busy !== 1'b0) begin
            errors++;
            $display("FAIL null_status got err=%b win=%0d busy=%b want 0 4 0",
                     cfg_err, s_win, s_busy);
        end
    endtask

    task automatic test_abort();
        bit hit;
        @(negedge clk);
        clear_log();
        cfg_window    = 3'd2;
        cfg_num_tiles = 16'd2;
        cfg_rd_base   = 10'h10;
        cfg_wr_base   = 10'h30;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit   = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (rd_en && rd_addr == 10'h12) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL abort_find got no read at 0x12 want read");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({rd_en, pool_enable, pool_in_valid, wr_en, busy} !== 5'b0) begin
            errors++;
            $display("FAIL abort_drop got %b want 00000",
                     {rd_en, pool_enable, pool_in_valid, wr_en, busy});
        end
        repeat (20) @(negedge clk);
        checks++;
        if (ndone != 0 || rq.size() != 3) begin
            errors++;
            $display("FAIL abort_after got done=%0d rd=%0d want 0 3",
                     ndone, rq.size());
        end
        run_job(3'd1, 16'd1, 10'h10, 10'h30);
        checks++;
        if (ndone != 1 || rq.size() != 4 || wq.size() != 4) begin
            errors++;
            $display("FAIL abort_rerun got done=%0d rd=%0d wr=%0d want 1 4 4",
                     ndone, rq.size(), wq.size());
        end
        checks++;
        if (wq.size() > 0 && wq[0] !== 10'h30) begin
            errors++;
            $display("FAIL abort_rerun_wa got %0h want 30", wq[0]);
        end
    endtask

    task automatic test_start_ignored();
        @(negedge clk);
        clear_log();
        cfg_window    = 3'd2;
        cfg_num_tiles = 16'd1;
        cfg_rd_base   = 10'h100;
        cfg_wr_base   = 10'h200;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        cfg_window    = 3'd3;
        cfg_num_tiles = 16'd5;
        cfg_rd_base   = 10'h0;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (5) @(negedge clk);
        checks++;
        if (rq.size() != 4 || ndone != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start got rd=%0d done=%0d busy=%b want 4 1 0",
                     rq.size(), ndone, busy);
        end
        checks++;
        if (rq.size() == 4 && (rq[0] !== 10'h100 || rq[3] !== 10'h103)) begin
            errors++;
            $display("FAIL busy_start_addr got %0h..%0h want 100..103",
                     rq[0], rq[3]);
        end
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_err got %b want 0", cfg_err);
        end
    endtask

    task automatic test_start_abort();
        @(negedge clk);
        clear_log();
        cfg_window    = 3'd2;
        cfg_num_tiles = 16'd1;
        cfg_rd_base   = 10'd0;
        cfg_wr_base   = 10'd0;
        start         = 1'b1;
        abort         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_abort_busy got %b want 1", busy);
        end
        wait_done("start_abort");
        checks++;
        if (ndone != 1 || rq.size() != 4) begin
            errors++;
            $display("FAIL start_abort got done=%0d rd=%0d want 1 4",
                     ndone, rq.size());
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        clear_log();
        no_done       = 1'b1;
        cfg_window    = 3'd2;
        cfg_num_tiles = 16'd1;
        cfg_rd_base   = 10'd0;
        cfg_wr_base   = 10'd0;
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || pool_enable !== 1'b1 || rd_en !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold got busy=%b en=%b rd=%b want 1 1 0",
                     busy, pool_enable, rd_en);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en, wr_en, pool_enable, pool_in_valid, cfg_err} !== 7'b0
            || pool_window !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset got %b win=%0d want 0000000 0",
                     {busy, done, rd_en, wr_en, pool_enable, pool_in_valid, cfg_err},
                     pool_window);
        end
        @(negedge clk);
        resetn  = 1'b1;
        no_done = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL mid_reset_done got %0d want 0", ndone);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] e;
        run_job(3'd4, 16'd1, 10'd1022, 10'd1022);
        checks++;
        if (rq.size() != 4 || wq.size() != 4) begin
            errors++;
            $display("FAIL wrap_counts got rd=%0d wr=%0d want 4 4",
                     rq.size(), wq.size());
        end
        for (int i = 0; i < wq.size() && i < 4; i++) begin
            e = AW'(1022 + i);
            checks++;
            if (wq[i] !== e || rq[i] !== e || dq[i] !== pat(e)) begin
                errors++;
                $display("FAIL wrap%0d got wa=%0d ra=%0d want %0d",
                         i, wq[i], rq[i], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_multi_tile();
        test_bad_window();
        test_null_job();
        test_abort();
        test_start_ignored();
        test_start_abort();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
